uart_rx_word: RTL
=================

// Module: uart_rx_word
// PURPOSE
//  UART receiver (8N1, LSB first) that pairs received bytes into 16-bit words.
//  It is the host-to-board counterpart of the board's UART transmitter.
//  Output words (DRAM16 data or commands) go to the DRAM write/read controller over a valid/ready handshake.
//  Sits between the board uart_rxd pin and the controller.
// PARAMETERS
//  CLKS_PER_BIT  1736  clk cycles per bit (200 MHz / 115200); must be >= 4.
//  TIMEOUT_BITS  20    idle bit-times allowed between the two bytes of one word.
// PORTS
//  clk         in   1   system clock, 200 MHz
//  rst         in   1   synchronous reset, active-high
//  uart_rxd    in   1   async serial input; idle level 1
//  word_data   out  16  [16:1]; first byte -> [16:9], second byte -> [8:1]
//  word_valid  out  1   word_data holds an unconsumed word
//  word_ready  in   1   consumer accepts the word when word_valid&&word_ready
//  frame_err   out  1   1-cycle pulse when a stop bit samples 0
//  overrun     out  1   sticky; set when a completed word is dropped; cleared only by rst
//  rx_busy     out  1   1 in every state except IDLE
// BEHAVIOUR
//  Reset values:
//   - sync FFs = 1, state = IDLE, all counters = 0, half_full = 0.
//   - word_data = 0, word_valid = 0, frame_err = 0, overrun = 0.
//  Input sync: two-flop synchronizer; rxd_s is the second flop. No other logic uses uart_rxd.
//  FSM (cnt = bit-timing counter, reset to 0 on every state entry):
//   - IDLE:  rxd_s==0 -> START.
//   - START: at cnt==CLKS_PER_BIT/2-1, rxd_s==0 -> DATA (bit_idx=0). rxd_s==1 -> IDLE (glitch, nothing reported).
//   - DATA:  at cnt==CLKS_PER_BIT-1, shift rxd_s in LSB first and increment bit_idx. After the 8th sample -> STOP.
//   - STOP:  at cnt==CLKS_PER_BIT-1:
//       rxd_s==1 -> byte accepted -> IDLE.
//       rxd_s==0 -> pulse frame_err, discard the byte, clear half_full -> BREAK.
//   - BREAK: wait for rxd_s==1 -> IDLE. A held-low line never re-triggers START.
//  Word assembly:
//   - Accepted byte with half_full==0: store it in the hi register; half_full=1.
//   - Accepted byte with half_full==1: the word is complete; half_full=0.
//  Output register (1-word buffer):
//   - A completed word loads word_data and sets word_valid on the cycle after the stop sample.
//   - Load is allowed only if word_valid==0, or word_valid&&word_ready in that same cycle.
//   - Otherwise the new word is dropped and overrun is set. word_data keeps the old word.
//   - word_valid&&word_ready with no new load: word_valid -> 0 next cycle. word_data holds its value.
//   - word_data is stable while word_valid==1 and word_ready==0.
//  Inter-byte timeout:
//   - gap counter runs only in IDLE while half_full==1. It resets when IDLE is left.
//   - Reaching TIMEOUT_BITS*CLKS_PER_BIT clears half_full, discarding the stored byte silently.
//   - No error output is raised for a timeout.
//  Reset mid-frame: returns to reset values on the next edge. The partial byte/word is lost; overrun is cleared.
//  Latency: the stop-bit sample falls ~9.5 bit-times after the start edge (+2 sync cycles); word_valid follows 1 cycle later.
// TESTING (sim with CLKS_PER_BIT=16, TIMEOUT_BITS=4)
//  1. Bytes 0xA5 then 0x5A, word_ready=1 -> one word_valid pulse, word_data=16'hA55A, frame_err=0, overrun=0.
//  2. Low glitch of 5 cycles on idle line -> state back to IDLE, no word_valid, no frame_err.
//  3. Byte 0x12 with stop bit forced 0, line high after 3 bit-times, then 0x34,0x56
//     -> one frame_err pulse; BREAK until the line is high; then word_data=16'h3456.
//  4. Byte 0x11, line idle for 5 bit-times, then 0x22,0x33 -> word_data=16'h2233; 0x11 never appears.
//  5. word_ready=0; send 0x0102 then 0x0304 -> word_data stays 16'h0102, overrun=1.
//     Raise word_ready -> accepted; overrun stays 1 until rst.
//  6. rst=1 pulse during DATA of the second byte, then send 0xBEEF
//     -> all outputs 0 after rst; next word_data=16'hBEEF.

Source files
------------

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 8N1 UART receiver pairing bytes into 16-bit words
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 1736,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [16:1] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        rx_busy
);

  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_LIMIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state, state_next;
  logic            rxd_m, rxd_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      hi_byte;
  logic            half_full;
  logic [GW-1:0]   gap_cnt;

  logic bit_end, stop_sample, byte_ok, byte_bad, word_done, load_ok;

  assign bit_end     = (cnt == BIT_LAST);
  assign stop_sample = (state == STOP) && bit_end;
  assign byte_ok     = stop_sample && rxd_s;
  assign byte_bad    = stop_sample && !rxd_s;
  assign word_done   = byte_ok && half_full;
  assign load_ok     = !word_valid || word_ready;
  assign rx_busy     = (state != IDLE);

  // Two-flop synchronizer on the asynchronous serial pin
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; BREAK holds until the line returns high so a stuck-low line cannot restart a frame
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rxd_s) state_next = START;
      START:   if (cnt == HALF_LAST) state_next = rxd_s ? IDLE : DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = rxd_s ? IDLE : BREAK;
      BREAK:   if (rxd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit-timing counter: cleared on every state change and after each data sample
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_next != state || (state == DATA && bit_end)) begin
      cnt <= '0;
    end else if (state == START || state == DATA || state == STOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data bit shifter, LSB arrives first so it ends up in bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == START) begin
      bit_idx <= '0;
    end else if (state == DATA && bit_end) begin
      shreg   <= {rxd_s, shreg[7:1]};
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Byte pairing and the inter-byte timeout that drops a lone first byte
  always_ff @(posedge clk) begin
    if (rst) begin
      half_full <= 1'b0;
      hi_byte   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == IDLE && half_full) begin
        if (gap_cnt == GAP_END) begin
          half_full <= 1'b0;
          gap_cnt   <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end else begin
        gap_cnt <= '0;
      end
      if (byte_ok) begin
        if (half_full) begin
          half_full <= 1'b0;
        end else begin
          hi_byte   <= shreg;
          half_full <= 1'b1;
        end
      end else if (byte_bad) begin
        half_full <= 1'b0;
      end
    end
  end

  // One-word output buffer with sticky overrun and a single-cycle frame error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= byte_bad;
      if (word_done && load_ok) begin
        word_data  <= {hi_byte, shreg};
        word_valid <= 1'b1;
      end else begin
        if (word_done) overrun <= 1'b1;
        if (word_valid && word_ready) word_valid <= 1'b0;
      end
    end
  end

endmodule
